score_display: RTL and testbench

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display.sv | 77 +++++++
 tb/tb_score_display.sv | 127 ++++++++++++
 2 files changed

// File: rtl/score_display.sv
// score_display: scans a four-digit BCD score onto a multiplexed active-low 7-segment display.
//   Clk, Reset            clock and asynchronous active-high reset
//   score0..score3        BCD digits (ones..thousands), sampled once per frame
//   blank_lz              suppress leading zeros on digits 3..1
//   hold                  keep the current snapshot at the next frame boundary
//   seg_n, an_n           active-low segments (a..g) and digit enables
//   digit_sel             digit being scanned; frame_done pulses after each full scan
module score_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] score0,
  input  logic [7:0] score1,
  input  logic [7:0] score2,
  input  logic [7:0] score3,
  input  logic       blank_lz,
  input  logic       hold,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic [1:0] digit_sel,
  output logic       frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            frame_q;
  logic [3:0][7:0] snap_q;
  logic            wrap, boundary;
  logic [7:0]      cur;
  logic [3:0]      lz;
  logic [6:0]      glyph;
  assign wrap     = cnt_q == CW'(REFRESH_DIV - 1);
  assign boundary = wrap && sel_q == 2'd3;
  assign cnt_d    = wrap ? '0 : cnt_q + CW'(1);
  assign sel_d    = wrap ? sel_q + 2'd1 : sel_q;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q   <= '0;
      sel_q   <= '0;
      frame_q <= 1'b0;
      snap_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      frame_q <= boundary;
      if (boundary && !hold) snap_q <= {score3, score2, score1, score0};
    end
  end
  // A digit is a leading zero only if it and every higher digit are zero;
  // an invalid digit is non-zero, so it also ends blanking below it.
  assign lz[3] = snap_q[3] == 8'd0;
  assign lz[2] = lz[3] && snap_q[2] == 8'd0;
  assign lz[1] = lz[2] && snap_q[1] == 8'd0;
  assign lz[0] = 1'b0;
  assign cur = snap_q[sel_q];
  always_comb begin
    case (cur)
      8'd0:    glyph = 7'b1000000;
      8'd1:    glyph = 7'b1111001;
      8'd2:    glyph = 7'b0100100;
      8'd3:    glyph = 7'b0110000;
      8'd4:    glyph = 7'b0011001;
      8'd5:    glyph = 7'b0010010;
      8'd6:    glyph = 7'b0000010;
      8'd7:    glyph = 7'b1111000;
      8'd8:    glyph = 7'b0000000;
      8'd9:    glyph = 7'b0010000;
      default: glyph = 7'b0111111;
    endcase
  end
  assign seg_n      = blank_lz && lz[sel_q] ? 7'b1111111 : glyph;
  // The first cycle of every digit slot is dead time to avoid ghosting.
  assign an_n       = cnt_q == '0 ? 4'b1111 : ~(4'b0001 << sel_q);
  assign digit_sel  = sel_q;
  assign frame_done = frame_q;
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed frames checked by a queue-based scoreboard monitor.
module tb_score_display;
  localparam int DIV = 4;
  localparam int FR  = 4 * DIV;
  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100, D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001, D5 = 7'b0010010, D6 = 7'b0000010, D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000, D9 = 7'b0010000, B = 7'b1111111, DASH = 7'b0111111;
  typedef struct packed {
    logic [3:0][6:0] s;
    logic            chk;
  } exp_t;
  logic       Clk = 1'b0, Reset = 1'b1, blank_lz = 1'b0, hold = 1'b0;
  logic [7:0] score0 = 8'd1, score1 = 8'd2, score2 = 8'd3, score3 = 8'd4;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic [1:0] digit_sel;
  logic       frame_done;
  exp_t       q[$];
  exp_t       e;
  logic [3:0] ea;
  int         vectors = 0, miscompares = 0, cyc = 0, last = 0;

  score_display #(.REFRESH_DIV(DIV)) dut (
    .Clk(Clk), .Reset(Reset),
    .score0(score0), .score1(score1), .score2(score2), .score3(score3),
    .blank_lz(blank_lz), .hold(hold),
    .seg_n(seg_n), .an_n(an_n), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_sc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    score0 = a; score1 = b; score2 = c; score3 = d;
  endtask

  // Wait for the next frame boundary, then queue the expected glyphs (digit 0 first) for that frame.
  task automatic frame(input logic bl, input logic [6:0] e0, input logic [6:0] e1,
                       input logic [6:0] e2, input logic [6:0] e3, input logic chk);
    int n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (!frame_done && n < 2 * FR);
    check("frame_seen", {7'd0, frame_done}, 8'd1);
    check("frame_period", 8'(cyc - last), 8'(FR));
    last = cyc;
    blank_lz = bl;
    q.push_back('{s: {e3, e2, e1, e0}, chk: chk});
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      if (frame_done && !Reset) begin
        if (q.size() == 0) check("frame_queue", 8'(q.size()), 8'd1);
        else begin
          e = q.pop_front();
          if (e.chk) begin
            for (int j = 0; j < FR; j++) begin
              if (j > 0) @(negedge Clk);
              ea = (j % DIV == 0) ? 4'b1111 : ~(4'b0001 << (j / DIV));
              check("digit_sel", {6'd0, digit_sel}, 8'(j / DIV));
              check("an_n", {4'd0, an_n}, {4'd0, ea});
              check("seg_n", {1'b0, seg_n}, {1'b0, e.s[j / DIV]});
              check("frame_done", {7'd0, frame_done}, {7'd0, j == 0});
            end
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    check("rst_seg_n", {1'b0, seg_n}, {1'b0, D0});
    check("rst_an_n", {4'd0, an_n}, 8'h0f);
    check("rst_digit_sel", {6'd0, digit_sel}, 8'd0);
    check("rst_frame_done", {7'd0, frame_done}, 8'd0);
    Reset = 1'b0;
    last = cyc;
    frame(1'b0, D1, D2, D3, D4, 1'b1); set_sc(8'd7, 8'd0, 8'd0, 8'd0);
    frame(1'b1, D7, B, B, B, 1'b1);    set_sc(8'd0, 8'd0, 8'd0, 8'd0);
    frame(1'b1, D0, B, B, B, 1'b1);    set_sc(8'd5, 8'd0, 8'd12, 8'd0);
    frame(1'b1, D5, D0, DASH, B, 1'b1);
    frame(1'b0, D5, D0, DASH, D0, 1'b1); set_sc(8'd3, 8'd0, 8'd0, 8'd255);
    frame(1'b1, D3, D0, D0, DASH, 1'b1); set_sc(8'd0, 8'd6, 8'd0, 8'd0);
    frame(1'b1, D0, D6, B, B, 1'b1);   set_sc(8'd1, 8'd2, 8'd3, 8'd4);
    frame(1'b0, D1, D2, D3, D4, 1'b1); hold = 1'b1; set_sc(8'd9, 8'd9, 8'd9, 8'd9);
    frame(1'b0, D1, D2, D3, D4, 1'b1); hold = 1'b0;
    frame(1'b0, D9, D9, D9, D9, 1'b1);
    repeat (6) @(posedge Clk);
    #1;
    check("mid_digit_sel", {6'd0, digit_sel}, 8'd1);
    set_sc(8'd8, 8'd8, 8'd8, 8'd8);
    frame(1'b0, D8, D8, D8, D8, 1'b1); set_sc(8'd2, 8'd0, 8'd0, 8'd0);
    frame(1'b1, B, B, B, B, 1'b0);
    repeat (9) @(posedge Clk);
    #3;
    check("pre_rst_digit_sel", {6'd0, digit_sel}, 8'd2);
    Reset = 1'b1;
    #1;
    check("async_seg_n", {1'b0, seg_n}, {1'b0, D0});
    check("async_an_n", {4'd0, an_n}, 8'h0f);
    check("async_digit_sel", {6'd0, digit_sel}, 8'd0);
    check("async_frame_done", {7'd0, frame_done}, 8'd0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    last = cyc;
    frame(1'b1, D2, B, B, B, 1'b1);
    repeat (FR - 1) @(posedge Clk);
    @(negedge Clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
